// File: rtl/bsg_murn_converter_buffered.sv
// Per-node bridge between bsg valid/ready|yumi host channels and murn valid/retry switch ports.
// Each node has an optional s2b FIFO, a b2s FIFO, a flush and a sticky protocol-error flag.
module bsg_murn_converter_buffered #(
  parameter int unsigned nodes_p      = 1,
  parameter int unsigned ring_width_p = 8,
  parameter int unsigned s2b_els_p    = 0,
  parameter int unsigned b2s_els_p    = 2,
  parameter int unsigned cnt_width_p  =
    $clog2(((s2b_els_p > b2s_els_p) ? s2b_els_p : b2s_els_p) + 1)
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic [nodes_p-1:0]                      flush_i,
  input  logic [nodes_p-1:0]                      v_i,
  output logic [nodes_p-1:0]                      ready_o,
  input  logic [nodes_p-1:0][ring_width_p-1:0]    data_i,
  output logic [nodes_p-1:0]                      switch_2_blockValid,
  input  logic [nodes_p-1:0]                      switch_2_blockRetry,
  output logic [nodes_p-1:0][ring_width_p-1:0]    switch_2_blockData,
  input  logic [nodes_p-1:0]                      block_2_switchValid,
  output logic [nodes_p-1:0]                      block_2_switchRetry,
  input  logic [nodes_p-1:0][ring_width_p-1:0]    block_2_switchData,
  output logic [nodes_p-1:0]                      v_o,
  input  logic [nodes_p-1:0]                      yumi_i,
  output logic [nodes_p-1:0][ring_width_p-1:0]    data_o,
  output logic [nodes_p-1:0][cnt_width_p-1:0]     s2b_count_o,
  output logic [nodes_p-1:0][cnt_width_p-1:0]     b2s_count_o,
  output logic [nodes_p-1:0]                      proto_err_o
);

  // Goes high one edge after reset release so traffic starts a cycle later.
  logic [nodes_p-1:0] live_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) live_r <= '0;
    else            live_r <= '1;
  end

  always_ff @(posedge clk_i) begin
    assert (b2s_els_p >= 2) else $error("b2s_els_p must be >= 2");
    assert (s2b_els_p != 1) else $error("s2b_els_p must be 0 or >= 2");
  end

  for (genvar i = 0; i < nodes_p; i++) begin : g_node

    // ---------------- b2s: murn block -> host ----------------
    localparam int unsigned BPW = (b2s_els_p > 2) ? $clog2(b2s_els_p) : 1;

    logic [ring_width_p-1:0] b2s_mem [b2s_els_p];
    logic [BPW-1:0]          b2s_rd, b2s_wr;
    logic [cnt_width_p-1:0]  b2s_cnt;
    logic                    b2s_err, b2s_enq, b2s_deq;

    assign block_2_switchRetry[i] = ~live_r[i] | flush_i[i] |
                                    (b2s_cnt == cnt_width_p'(b2s_els_p));
    assign b2s_enq        = block_2_switchValid[i] & ~block_2_switchRetry[i];
    assign v_o[i]         = (b2s_cnt != '0);
    assign b2s_deq        = yumi_i[i] & v_o[i];
    assign data_o[i]      = b2s_mem[b2s_rd];
    assign b2s_count_o[i] = b2s_cnt;
    assign proto_err_o[i] = b2s_err;

    always_ff @(posedge clk_i) begin
      if (b2s_enq) b2s_mem[b2s_wr] <= block_2_switchData[i];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        b2s_rd  <= '0;
        b2s_wr  <= '0;
        b2s_cnt <= '0;
        b2s_err <= 1'b0;
      end else if (flush_i[i]) begin
        b2s_rd  <= '0;
        b2s_wr  <= '0;
        b2s_cnt <= '0;
        b2s_err <= 1'b0;
      end else begin
        if (b2s_enq) b2s_wr <= (b2s_wr == BPW'(b2s_els_p - 1)) ? '0 : b2s_wr + 1'b1;
        if (b2s_deq) b2s_rd <= (b2s_rd == BPW'(b2s_els_p - 1)) ? '0 : b2s_rd + 1'b1;
        b2s_cnt <= b2s_cnt + cnt_width_p'(b2s_enq) - cnt_width_p'(b2s_deq);
        // A word offered while retry is up is dropped and flagged.
        if (block_2_switchValid[i] & block_2_switchRetry[i]) b2s_err <= 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (reset_n_i) assert (!(yumi_i[i] && !v_o[i])) else $error("yumi_i without v_o");
    end

    // ---------------- s2b: host -> murn block ----------------
    if (s2b_els_p == 0) begin : g_pass
      // Valid is gated during flush so the switch never takes a word the host thinks is refused.
      assign switch_2_blockValid[i] = v_i[i] & live_r[i] & ~flush_i[i];
      assign ready_o[i]             = live_r[i] & ~switch_2_blockRetry[i] & ~flush_i[i];
      assign switch_2_blockData[i]  = data_i[i];
      assign s2b_count_o[i]         = '0;
    end else begin : g_fifo
      localparam int unsigned SPW = (s2b_els_p > 2) ? $clog2(s2b_els_p) : 1;

      logic [ring_width_p-1:0] s2b_mem [s2b_els_p];
      logic [SPW-1:0]          s2b_rd, s2b_wr;
      logic [cnt_width_p-1:0]  s2b_cnt;
      logic                    s2b_enq, s2b_deq;

      // ready_o deliberately ignores retry: full blocks enqueue even if a dequeue is pending.
      assign ready_o[i]             = live_r[i] & ~flush_i[i] &
                                      (s2b_cnt != cnt_width_p'(s2b_els_p));
      assign s2b_enq                = v_i[i] & ready_o[i];
      assign switch_2_blockValid[i] = (s2b_cnt != '0);
      assign s2b_deq                = switch_2_blockValid[i] & ~switch_2_blockRetry[i];
      assign switch_2_blockData[i]  = s2b_mem[s2b_rd];
      assign s2b_count_o[i]         = s2b_cnt;

      always_ff @(posedge clk_i) begin
        if (s2b_enq) s2b_mem[s2b_wr] <= data_i[i];
      end

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          s2b_rd  <= '0;
          s2b_wr  <= '0;
          s2b_cnt <= '0;
        end else if (flush_i[i]) begin
          s2b_rd  <= '0;
          s2b_wr  <= '0;
          s2b_cnt <= '0;
        end else begin
          if (s2b_enq) s2b_wr <= (s2b_wr == SPW'(s2b_els_p - 1)) ? '0 : s2b_wr + 1'b1;
          if (s2b_deq) s2b_rd <= (s2b_rd == SPW'(s2b_els_p - 1)) ? '0 : s2b_rd + 1'b1;
          s2b_cnt <= s2b_cnt + cnt_width_p'(s2b_enq) - cnt_width_p'(s2b_deq);
        end
      end
    end
  end

endmodule

// File: tb/tb_bsg_murn_converter_buffered.sv
// Directed bench: buffered 2-node instance (s2b=3, b2s=4) plus a 1-node pass-through instance.
module tb_bsg_murn_converter_buffered;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [1:0]      flush, v_i, ready, sv, sr, bv, br, v_o, yumi, perr;
  logic [1:0][7:0] din, sd, bd, dout;
  logic [1:0][2:0] s2b_cnt, b2s_cnt;

  logic       pt_flush, pt_v, pt_ready, pt_sv, pt_sr, pt_bv, pt_br, pt_vo, pt_yumi, pt_perr;
  logic [7:0] pt_din, pt_sd, pt_bd, pt_dout;
  logic [1:0] pt_s2b_cnt, pt_b2s_cnt;

  bsg_murn_converter_buffered #(
    .nodes_p(2), .ring_width_p(8), .s2b_els_p(3), .b2s_els_p(4)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .v_i(v_i), .ready_o(ready),
    .data_i(din), .switch_2_blockValid(sv), .switch_2_blockRetry(sr),
    .switch_2_blockData(sd), .block_2_switchValid(bv), .block_2_switchRetry(br),
    .block_2_switchData(bd), .v_o(v_o), .yumi_i(yumi), .data_o(dout),
    .s2b_count_o(s2b_cnt), .b2s_count_o(b2s_cnt), .proto_err_o(perr)
  );

  bsg_murn_converter_buffered #(
    .nodes_p(1), .ring_width_p(8), .s2b_els_p(0), .b2s_els_p(2)
  ) dut_pt (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(pt_flush), .v_i(pt_v), .ready_o(pt_ready),
    .data_i(pt_din), .switch_2_blockValid(pt_sv), .switch_2_blockRetry(pt_sr),
    .switch_2_blockData(pt_sd), .block_2_switchValid(pt_bv), .block_2_switchRetry(pt_br),
    .block_2_switchData(pt_bd), .v_o(pt_vo), .yumi_i(pt_yumi), .data_o(pt_dout),
    .s2b_count_o(pt_s2b_cnt), .b2s_count_o(pt_b2s_cnt), .proto_err_o(pt_perr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       bvi;
    logic [7:0] bdi;
    logic       yi;
    logic       e_retry;
    logic       e_v;
    logic [7:0] e_data;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t tbl[15];
  logic [7:0] sb[$];
  logic [7:0] exp_w;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // b2s fill/drain on node 0, then simultaneous enq+deq at count 2
    tbl[0]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[1]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 8'hA0, 3'd1};
    tbl[2]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA0, 3'd2};
    tbl[3]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA0, 3'd3};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA0, 3'd4};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA0, 3'd4};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA1, 3'd3};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA2, 3'd2};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA3, 3'd1};
    tbl[9]  = '{1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[10] = '{1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 8'hB0, 3'd1};
    tbl[11] = '{1'b1, 8'hB5, 1'b1, 1'b0, 1'b1, 8'hB0, 3'd2};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB1, 3'd2};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB5, 3'd1};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};

    reset_n = 1'b0;
    flush = '0; v_i = '0; sr = '0; bv = '0; yumi = '0; din = '0; bd = '0;
    pt_flush = 0; pt_v = 0; pt_sr = 0; pt_bv = 0; pt_yumi = 0; pt_din = '0; pt_bd = '0;

    // reset
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("rst_ready_c0", ready, 2'b00);
    chk("rst_retry_c0", br, 2'b11);
    chk("rst_v_o", v_o, 2'b00);
    chk("rst_sv", sv, 2'b00);
    chk("rst_perr", perr, 2'b00);
    chk("rst_pt_ready_c0", pt_ready, 1'b0);
    tick();
    chk("rst_ready_c1", ready, 2'b11);
    chk("rst_retry_c1", br, 2'b00);
    chk("rst_pt_ready_c1", pt_ready, 1'b1);

    // b2s table
    for (int r = 0; r < 15; r++) begin
      bv[0] = tbl[r].bvi; bd[0] = tbl[r].bdi; yumi[0] = tbl[r].yi;
      #1;
      chk($sformatf("tbl%0d_retry", r), br[0], tbl[r].e_retry);
      chk($sformatf("tbl%0d_v", r), v_o[0], tbl[r].e_v);
      chk($sformatf("tbl%0d_cnt", r), b2s_cnt[0], tbl[r].e_cnt);
      if (tbl[r].e_v) chk($sformatf("tbl%0d_data", r), dout[0], tbl[r].e_data);
      tick();
    end
    bv = '0; yumi = '0;

    // protocol error: fill, offer 0xDE under retry, drain, flush
    for (int k = 0; k < 4; k++) begin
      bv[0] = 1'b1; bd[0] = 8'hC0 + 8'(k);
      tick();
    end
    bd[0] = 8'hDE;
    #1;
    chk("perr_retry", br[0], 1'b1);
    tick();
    bv[0] = 1'b0;
    #1;
    chk("perr_set", perr[0], 1'b1);
    chk("perr_cnt", b2s_cnt[0], 3'd4);
    for (int k = 0; k < 4; k++) begin
      yumi[0] = 1'b1;
      #1;
      chk($sformatf("perr_drain%0d", k), dout[0], 8'hC0 + 8'(k));
      tick();
    end
    yumi[0] = 1'b0;
    #1;
    chk("perr_empty", v_o[0], 1'b0);
    chk("perr_sticky", perr[0], 1'b1);
    flush[0] = 1'b1;
    #1;
    chk("flush_ready", ready[0], 1'b0);
    chk("flush_retry", br[0], 1'b1);
    tick();
    flush[0] = 1'b0;
    #1;
    chk("perr_cleared", perr[0], 1'b0);

    // s2b under held retry: buffered vs pass-through
    sr[0] = 1'b1; pt_sr = 1'b1; v_i[0] = 1'b1; pt_v = 1'b1; pt_din = 8'hD0;
    for (int k = 0; k < 5; k++) begin
      din[0] = 8'hD0 + 8'((k < 3) ? k : 3);
      #1;
      chk($sformatf("s2b_ready%0d", k), ready[0], (k < 3) ? 1'b1 : 1'b0);
      chk($sformatf("pt_ready%0d", k), pt_ready, 1'b0);
      chk($sformatf("pt_sv%0d", k), pt_sv, 1'b1);
      tick();
    end
    v_i[0] = 1'b0; pt_v = 1'b0;
    #1;
    chk("s2b_cnt_full", s2b_cnt[0], 3'd3);
    sr[0] = 1'b0; pt_sr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("s2b_out_v%0d", k), sv[0], 1'b1);
      chk($sformatf("s2b_out_d%0d", k), sd[0], 8'hD0 + 8'(k));
      tick();
    end
    #1;
    chk("s2b_drained", sv[0], 1'b0);
    chk("s2b_cnt_zero", s2b_cnt[0], 3'd0);
    pt_v = 1'b1; pt_din = 8'hD9;
    #1;
    chk("pt_ready_open", pt_ready, 1'b1);
    chk("pt_data", pt_sd, 8'hD9);
    pt_v = 1'b0;
    tick();

    // node 1 preload: 3 words in each direction
    sr[1] = 1'b1; v_i[1] = 1'b1; bv[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din[1] = 8'h60 + 8'(k); bd[1] = 8'h70 + 8'(k);
      tick();
    end
    v_i[1] = 1'b0; bv[1] = 1'b0;
    #1;
    chk("n1_s2b_cnt", s2b_cnt[1], 3'd3);
    chk("n1_b2s_cnt", b2s_cnt[1], 3'd3);
    chk("n1_head", dout[1], 8'h70);

    // node 0 streams while node 1 is flushed
    for (int k = 0; k < 8; k++) begin
      bv[0] = 1'b1; bd[0] = 8'hE0 + 8'(k); yumi[0] = v_o[0];
      flush[1] = (k == 3); v_i[1] = (k == 3); bv[1] = (k == 3);
      #1;
      if (k >= 1) chk($sformatf("stream_v%0d", k), v_o[0], 1'b1);
      chk($sformatf("stream_retry%0d", k), br[0], 1'b0);
      if (yumi[0]) begin
        exp_w = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        chk($sformatf("stream_d%0d", k), dout[0], exp_w);
      end
      if (k == 3) begin
        chk("n1_flush_ready", ready[1], 1'b0);
        chk("n1_flush_retry", br[1], 1'b1);
      end
      sb.push_back(bd[0]);
      tick();
    end
    bv[0] = 1'b0; flush[1] = 1'b0; v_i[1] = 1'b0; bv[1] = 1'b0;
    yumi[0] = v_o[0];
    #1;
    exp_w = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    chk("stream_last", dout[0], exp_w);
    chk("n1_s2b_flushed", s2b_cnt[1], 3'd0);
    chk("n1_b2s_flushed", b2s_cnt[1], 3'd0);
    chk("n1_v_o_flushed", v_o[1], 1'b0);
    chk("n1_sv_flushed", sv[1], 1'b0);
    chk("n1_perr_flushed", perr[1], 1'b0);
    tick();
    yumi[0] = 1'b0; sr[1] = 1'b0;
    bv[1] = 1'b1; bd[1] = 8'h77;
    tick();
    bv[1] = 1'b0;
    #1;
    chk("n1_post_v", v_o[1], 1'b1);
    chk("n1_post_d", dout[1], 8'h77);
    chk("n1_post_cnt", b2s_cnt[1], 3'd1);
    chk("n0_idle", v_o[0], 1'b0);
    yumi[1] = 1'b1;
    tick();
    yumi[1] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
